// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequenced ROM address generator for LED pattern playback.
// Handles segment first/last, four play modes, pause/stop and a tick prescaler.
// ROM data is registered onto the LED bus once the ROM read latency has elapsed.
// Optional macro LED_BLANK_EN: blanks led to 8'h00 in IDLE and DONE.
module led_seq_ctrl #(
  parameter int unsigned ADR_W   = 5,
  parameter int unsigned SPD_W   = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [SPD_W-1:0] speed,
  input  logic [ADR_W-1:0] seg_first,
  input  logic [ADR_W-1:0] seg_last,
  input  logic [7:0]       rom_q,
  output logic [ADR_W-1:0] adr,
  output logic [7:0]       led,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_FWD  = 2'd0;
  localparam logic [1:0] M_REV  = 2'd1;
  localparam logic [1:0] M_PING = 2'd2;

  localparam int unsigned PIPE_W = ROM_LAT + 1;
  localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);
  localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);

  logic [1:0]        state, state_d;
  logic [ADR_W-1:0]  adr_d;
  logic [SPD_W-1:0]  pre, pre_d;
  logic              dir, dir_d;          // 1 = counting down (ping-pong only)
  logic [ADR_W-1:0]  first_r, first_d;
  logic [ADR_W-1:0]  last_r, last_d;
  logic [1:0]        mode_r, mode_d;
  logic [PIPE_W-1:0] pipe, pipe_d;
  logic [7:0]        led_d;
  logic              err_d;
  logic              strobe_c;
  logic              take_start_c;
  logic [ADR_W-1:0]  adv_adr_c;
  logic              adv_dir_c;
  logic              adv_fin_c;

  // Next address for one advance step under the latched mode
  always_comb begin
    adv_adr_c = adr;
    adv_dir_c = dir;
    adv_fin_c = 1'b0;
    case (mode_r)
      M_FWD:  adv_adr_c = (adr == last_r) ? first_r : adr + ADR_ONE;
      M_REV:  adv_adr_c = (adr == first_r) ? last_r : adr - ADR_ONE;
      M_PING: begin
        if (first_r != last_r) begin
          if (!dir) begin
            if (adr == last_r) begin
              adv_dir_c = 1'b1;
              adv_adr_c = last_r - ADR_ONE;
            end else begin
              adv_adr_c = adr + ADR_ONE;
            end
          end else begin
            if (adr == first_r) begin
              adv_dir_c = 1'b0;
              adv_adr_c = first_r + ADR_ONE;
            end else begin
              adv_adr_c = adr - ADR_ONE;
            end
          end
        end
      end
      default: begin
        if (adr == last_r) adv_fin_c = 1'b1;
        else               adv_adr_c = adr + ADR_ONE;
      end
    endcase
  end

  // FSM next state, playback datapath and LED capture
  always_comb begin
    state_d      = state;
    adr_d        = adr;
    pre_d        = pre;
    dir_d        = dir;
    first_d      = first_r;
    last_d       = last_r;
    mode_d       = mode_r;
    err_d        = 1'b0;
    strobe_c     = 1'b0;
    take_start_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) take_start_c = 1'b1;
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          take_start_c = 1'b1;
        end else if (pause) begin
          state_d = (state == S_RUN) ? S_PAUSE : S_RUN;
        end else if (state == S_RUN && tick) begin
          if (pre == speed) begin
            pre_d = '0;
            if (adv_fin_c) begin
              state_d = S_DONE;
            end else begin
              adr_d    = adv_adr_c;
              dir_d    = adv_dir_c;
              strobe_c = 1'b1;
            end
          end else begin
            pre_d = pre + SPD_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take_start_c) begin
      if (seg_first <= seg_last) begin
        first_d  = seg_first;
        last_d   = seg_last;
        mode_d   = mode;
        adr_d    = (mode == M_REV) ? seg_last : seg_first;
        pre_d    = '0;
        dir_d    = 1'b0;
        state_d  = S_RUN;
        strobe_c = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    pipe_d = stop ? '0 : {pipe[PIPE_W-2:0], strobe_c};
    led_d  = led;
    if (pipe[PIPE_W-1] && !stop) led_d = rom_q;
`ifdef LED_BLANK_EN
    if (state_d == S_IDLE || state_d == S_DONE) led_d = '0;
`endif
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      adr     <= '0;
      pre     <= '0;
      dir     <= 1'b0;
      first_r <= '0;
      last_r  <= '0;
      mode_r  <= '0;
      pipe    <= '0;
      led     <= '0;
      busy    <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      adr     <= adr_d;
      pre     <= pre_d;
      dir     <= dir_d;
      first_r <= first_d;
      last_r  <= last_d;
      mode_r  <= mode_d;
      pipe    <= pipe_d;
      led     <= led_d;
      busy    <= (state_d == S_RUN) || (state_d == S_PAUSE);
      paused  <= (state_d == S_PAUSE);
      done    <= (state_d == S_DONE);
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed plan items plus randomized playback against a
// behavioural model (segment stepping with a signed step, LED capture queue).
module tb_led_seq_ctrl;
  localparam int unsigned ADR_W   = 5;
  localparam int unsigned SPD_W   = 4;
  localparam int unsigned ROM_LAT = 1;
  localparam int          SPAN    = 1 << ADR_W;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [1:0]       mode = '0;
  logic [SPD_W-1:0] speed = '0;
  logic [ADR_W-1:0] seg_first = '0, seg_last = '0;
  logic [7:0]       rom_q;
  logic [ADR_W-1:0] adr;
  logic [7:0]       led;
  logic             busy, paused, done, err;

  led_seq_ctrl #(.ADR_W(ADR_W), .SPD_W(SPD_W), .ROM_LAT(ROM_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .mode(mode), .speed(speed), .seg_first(seg_first),
    .seg_last(seg_last), .rom_q(rom_q), .adr(adr), .led(led), .busy(busy),
    .paused(paused), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Pattern ROM with ROM_LAT cycles of read latency
  logic [7:0] rom [SPAN];
  logic [7:0] rom_pipe [ROM_LAT];
  assign rom_q = rom_pipe[ROM_LAT-1];
  always @(posedge CLK) begin
    rom_pipe[0] <= rom[adr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  typedef struct {int due; int a;} pend_t;
  mst_t  m_st;
  int    m_adr, m_pre, m_step, m_first, m_last, m_mode, m_led;
  bit    m_err;
  pend_t pend[$];
  int    edge_n = 0;

  task automatic model_reset();
    m_st = M_IDLE; m_adr = 0; m_pre = 0; m_step = 1;
    m_first = 0; m_last = 0; m_mode = 0; m_led = 0; m_err = 0;
    pend.delete();
  endtask

  // One clock edge of the playback rules applied to the given inputs
  task automatic model_step(input bit t, st, sp, pa, input int md, spd, f, l);
    bit push = 0;
    bit want = 0;
    m_err = 0;
    if (sp) pend.delete();
    else if (pend.size() > 0 && pend[0].due == edge_n) begin
      m_led = rom[pend[0].a];
      void'(pend.pop_front());
    end
    case (m_st)
      M_IDLE: want = st && !sp;
      M_DONE: m_st = M_IDLE;
      default: begin
        if (sp) m_st = M_IDLE;
        else if (st) want = 1;
        else if (pa) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        else if (m_st == M_RUN && t) begin
          if (m_pre == spd) begin
            m_pre = 0;
            case (m_mode)
              0: begin m_adr = (m_adr == m_last) ? m_first : (m_adr + 1) % SPAN; push = 1; end
              1: begin m_adr = (m_adr == m_first) ? m_last : (m_adr - 1 + SPAN) % SPAN; push = 1; end
              2: begin
                if (m_first != m_last) begin
                  if ((m_step > 0 && m_adr == m_last) || (m_step < 0 && m_adr == m_first))
                    m_step = -m_step;
                  m_adr = (m_adr + m_step + SPAN) % SPAN;
                end
                push = 1;
              end
              default: begin
                if (m_adr == m_last) m_st = M_DONE;
                else begin m_adr = m_adr + 1; push = 1; end
              end
            endcase
          end else m_pre = (m_pre + 1) % (1 << SPD_W);
        end
      end
    endcase
    if (want) begin
      if (f <= l) begin
        m_first = f; m_last = l; m_mode = md;
        m_adr = (md == 1) ? l : f;
        m_pre = 0; m_step = 1; m_st = M_RUN; push = 1;
      end else m_err = 1;
    end
    if (push) pend.push_back('{edge_n + ROM_LAT + 1, m_adr});
`ifdef LED_BLANK_EN
    if (m_st == M_IDLE || m_st == M_DONE) m_led = 0;
`endif
    edge_n++;
  endtask

  task automatic compare_all();
    check("adr",    32'(adr),    32'(m_adr));
    check("led",    32'(led),    32'(m_led));
    check("busy",   32'(busy),   32'(m_st == M_RUN || m_st == M_PAUSE));
    check("paused", 32'(paused), 32'(m_st == M_PAUSE));
    check("done",   32'(done),   32'(m_st == M_DONE));
    check("err",    32'(err),    32'(m_err));
  endtask

  // Drive one cycle at a negedge, step the model, compare at the next negedge
  task automatic cyc(input bit t, st, sp, pa, input int md, spd, f, l);
    tick = t; start = st; stop = sp; pause = pa;
    mode = 2'(md); speed = SPD_W'(spd);
    seg_first = ADR_W'(f); seg_last = ADR_W'(l);
    model_step(t, st, sp, pa, md, spd, f, l);
    @(negedge CLK);
    compare_all();
  endtask

  int t2 [5] = '{2, 3, 4, 2, 3};
  int t3 [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    for (int i = 0; i < SPAN; i++) rom[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    compare_all();

    // Plan 2: forward loop 2..4
    cyc(1, 1, 0, 0, 0, 0, 2, 4);
    check("t2_adr", 32'(adr), 32'(t2[0]));
    for (int k = 1; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 2, 4);
      check("t2_adr", 32'(adr), 32'(t2[k]));
    end
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 2, 4);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Plan 3: ping-pong 0..3, advance every 2 ticks
    cyc(1, 1, 0, 0, 2, 1, 0, 3);
    check("t3_adr", 32'(adr), 32'(t3[0]));
    for (int k = 1; k < 8; k++) begin
      cyc(1, 0, 0, 0, 2, 1, 0, 3);
      cyc(1, 0, 0, 0, 2, 1, 0, 3);
      check("t3_adr", 32'(adr), 32'(t3[k]));
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Plan 4: one-shot 5..6
    cyc(1, 1, 0, 0, 3, 0, 5, 6);
    check("t4_adr5", 32'(adr), 32'd5);
    cyc(1, 0, 0, 0, 3, 0, 5, 6);
    check("t4_adr6", 32'(adr), 32'd6);
    cyc(1, 0, 0, 0, 3, 0, 5, 6);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_hold", 32'(adr), 32'd6);
    cyc(1, 0, 0, 0, 3, 0, 5, 6);
    check("t4_done1", 32'(done), 32'd0);

    // Plan 5: rejected start, then stop beats start while running
    cyc(0, 1, 0, 0, 0, 0, 9, 3);
    check("t5_err", 32'(err), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_adr", 32'(adr), 32'd6);
    cyc(0, 0, 0, 0, 0, 0, 9, 3);
    check("t5_err1", 32'(err), 32'd0);
    cyc(1, 1, 0, 0, 0, 0, 0, 3);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 3);
    cyc(1, 1, 1, 0, 0, 0, 1, 2);
    check("t5_stop", 32'(busy), 32'd0);
    check("t5_stop_adr", 32'(adr), 32'd2);

    // Plan 6: pause at adr 3 then resume
    cyc(1, 1, 0, 0, 0, 0, 0, 10);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 10);
    cyc(1, 0, 0, 1, 0, 0, 0, 10);
    repeat (10) cyc(1, 0, 0, 0, 0, 0, 0, 10);
    check("t6_adr", 32'(adr), 32'd3);
    check("t6_paused", 32'(paused), 32'd1);
    cyc(1, 0, 0, 1, 0, 0, 0, 10);
    check("t6_resume", 32'(paused), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 10);
    check("t6_adr4", 32'(adr), 32'd4);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Plan 1: async reset mid-run at adr 7
    cyc(1, 1, 0, 0, 0, 0, 0, 10);
    repeat (7) cyc(1, 0, 0, 0, 0, 0, 0, 10);
    check("t1_pre", 32'(adr), 32'd7);
    tick = 0; start = 0; stop = 0; pause = 0;
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("t1_adr", 32'(adr), 32'd0);
    check("t1_led", 32'(led), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    compare_all();

    // Randomized playback
    for (int i = 0; i < 4000; i++) begin
      int f, l, spd;
      f = $urandom_range(0, SPAN - 1);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(0, SPAN - 1);
      else l = $urandom_range(f, (f + 6 > SPAN - 1) ? SPAN - 1 : f + 6);
      spd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << SPD_W) - 1) : $urandom_range(0, 2);
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
          $urandom_range(0, 3), spd, f, l);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Playback controller for the LED pattern ROM path. It replaces the free-running address counter with a sequenced address generator that supports segment start/end, four play modes, pause/stop and a speed prescaler on the divider tick. It also registers ROM data onto the LED bus, aligned to the ROM read latency.

Parameters:
ADR_W, 5, ROM address width (depth 2^ADR_W)
SPD_W, 4, width of speed prescale input
ROM_LAT, 1, clock cycles from address change to valid ROM q (1..3)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-high reset
tick  in  1  one-cycle enable from clock divider (cnt_div cout)
start  in  1  pulse; latch seg_first/seg_last/mode, begin playback
stop  in  1  pulse; abort to IDLE
pause  in  1  pulse; toggle RUN<->PAUSE
mode  in  2  00 fwd loop, 01 rev loop, 10 ping-pong, 11 one-shot fwd
speed  in  SPD_W  advance every speed+1 ticks
seg_first  in  ADR_W  segment first address
seg_last  in  ADR_W  segment last address
rom_q  in  8  ROM data
adr  out  ADR_W  ROM address
led  out  8  registered LED pattern
busy  out  1  high in RUN or PAUSE
paused  out  1  high in PAUSE
done  out  1  one-cycle pulse at one-shot completion
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async, RESET=1): state IDLE, adr=0, led=0, busy=0, paused=0, done=0, err=0, prescale count=0, direction=up, latency pipe cleared.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE: start with seg_first<=seg_last -> latch segment/mode, load adr (seg_last for mode 01, else seg_first), prescale=0, direction=up, -> RUN next cycle. start with seg_first>seg_last -> err=1 for one cycle, stay IDLE, adr unchanged.
- RUN: on tick, if prescale==speed then advance adr and prescale=0, else prescale+1. speed is sampled live; if it is lowered below the current count, the count advances on the next tick after it wraps at 2^SPD_W-1 (no clamping).
- Advance rules:
  - 00: adr==last ? first : adr+1.
  - 01: adr==first ? last : adr-1.
  - 10: up at last -> direction=down, adr=last-1; down at first -> direction=up, adr=first+1; if first==last, adr holds.
  - 11: adr+1 until last; an advance while adr==last -> DONE, adr holds last.
- DONE: done=1 for exactly one cycle, then IDLE.
- RUN + pause -> PAUSE: adr and prescale frozen, ticks ignored. PAUSE + pause -> RUN.
- stop in RUN/PAUSE/DONE -> IDLE next cycle; adr holds.
- Simultaneous events:
  - stop beats start and pause.
  - start in RUN/PAUSE restarts with new latched values (same error check; a rejected restart asserts err and keeps running unchanged).
  - start beats pause.
- Outputs: busy = state in {RUN, PAUSE}. paused = state==PAUSE. All outputs registered.
- LED path: each adr load/advance pushes a strobe into a ROM_LAT+1 stage pipe. led<=rom_q when the strobe exits. Net: led reflects rom_q[new adr] ROM_LAT+1 cycles after adr changes. stop/reset clears in-flight strobes.
- Width rules: adr arithmetic is modulo 2^ADR_W, but wrap is always governed by first/last, never natural overflow.

Optional Feature:
LED_BLANK_EN. Defined: led forced to 8'h00 in IDLE and DONE, and the pipe is ignored there. Undefined: led holds the last captured value after stop/done.

Test Plan:
1. Reset mid-RUN (adr=7) -> adr=0, led=0, busy=0 same cycle as RESET rise, independent of CLK.
2. mode=00, first=2, last=4, speed=0, tick every cycle -> adr 2,3,4,2,3; led tracks ROM[adr] ROM_LAT+1 cycles later.
3. mode=10, first=0, last=3, speed=1, tick every cycle -> adr changes every 2 ticks: 0,1,2,3,2,1,0,1.
4. mode=11, first=5, last=6, speed=0 -> adr 5,6; done pulses once on the next advance; busy falls; adr stays 6.
5. start with first=9, last=3 -> err=1 for one cycle, state IDLE, adr unchanged. Then stop+start same cycle while running -> IDLE.
6. pause at adr=3 for 10 ticks -> adr stays 3, paused=1. Second pause -> resumes at 4 after speed+1 ticks. With LED_BLANK_EN defined, stop -> led=00.
